// File: rtl/multi_debouncer_if.sv
// Debouncer channel bundle: raw switch inputs plus the sample qualifier in,
// debounced levels and edge/long-hold pulses out.
// Latency: none (wires only). Backpressure: none; all signals are level/pulse.
// Ports: i_din/i_sample_en driven by the master; o_dout/o_rise/o_fall/o_long_press by the slave.
interface multi_debouncer_if #(
  parameter int N_CH = 8
);
  logic [N_CH-1:0] i_din;
  logic            i_sample_en;
  logic [N_CH-1:0] o_dout;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_long_press;

  modport master (
    output i_din, i_sample_en,
    input  o_dout, o_rise, o_fall, o_long_press
  );

  modport slave (
    input  i_din, i_sample_en,
    output o_dout, o_rise, o_fall, o_long_press
  );
endinterface

// File: rtl/multi_debouncer.sv
// Per-channel switch debouncer with rise/fall pulses and optional long-press pulse.
// Latency: dout follows a clean din step 2+STABLE_CYCLES cycles later (sample_en high).
// Backpressure: none; every channel is evaluated every cycle, pulses are one cycle wide.
//
// Ports: clk, rst_n (async active-low); bus (slave modport of multi_debouncer_if):
//   i_din raw inputs, i_sample_en qualifier tick, o_dout debounced level,
//   o_rise/o_fall edge pulses, o_long_press hold pulse.
// Optional feature macro: DEB_LONG_PRESS_EN (hold counters + long_press pulse).
module multi_debouncer #(
  parameter int N_CH          = 8,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 1000,
  parameter int LONG_CYCLES   = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_debouncer_if.slave    bus
);

  // Reject configurations that would let a counter wrap.
  generate
    if (N_CH < 1 || N_CH > 8 || CNT_W < 1 || CNT_W > 30 ||
        STABLE_CYCLES < 1 || STABLE_CYCLES > (2**CNT_W) - 1 ||
        LONG_CYCLES < 1 || LONG_CYCLES > (2**CNT_W) - 1) begin : g_bad_param
      $error("multi_debouncer: parameter out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [N_CH-1:0]  r_sync1;
  logic [N_CH-1:0]  r_sync2;
  logic [N_CH-1:0]  r_dout;
  logic [N_CH-1:0]  r_rise;
  logic [N_CH-1:0]  r_fall;
  logic [CNT_W-1:0] r_cnt [N_CH];

  logic [N_CH-1:0]  w_dout_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [N_CH];

  // Any sample matching the current output restarts qualification, so a
  // single bounce cycle costs the full STABLE_CYCLES again.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_dout_nxt[i] = r_dout[i];
      w_cnt_nxt[i]  = r_cnt[i];
      if (r_sync2[i] == r_dout[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (bus.i_sample_en) begin
        if (r_cnt[i] == STABLE_LAST) begin
          w_dout_nxt[i] = r_sync2[i];
          w_cnt_nxt[i]  = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_dout  <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= bus.i_din;
      r_sync2 <= r_sync1;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_dout_nxt & ~r_dout;
      r_fall  <= ~w_dout_nxt & r_dout;
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign bus.o_dout = r_dout;
  assign bus.o_rise = r_rise;
  assign bus.o_fall = r_fall;

`ifdef DEB_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_VAL  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] r_hold [N_CH];
  logic [N_CH-1:0]  r_long;

  // Hold counter parks at LONG_CYCLES so the pulse fires once per press;
  // it only rearms after dout drops back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_long <= '0;
      for (int i = 0; i < N_CH; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!r_dout[i]) begin
          r_hold[i] <= '0;
          r_long[i] <= 1'b0;
        end else if (bus.i_sample_en && (r_hold[i] != LONG_VAL)) begin
          r_hold[i] <= r_hold[i] + CNT_W'(1);
          r_long[i] <= (r_hold[i] == LONG_LAST);
        end else begin
          r_long[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.o_long_press = r_long;
`else
  assign bus.o_long_press = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed timing scenarios plus randomized traffic,
// checked against a history-based reference model through an expectation queue.
// Latency/backpressure: n/a (bench).
module tb_multi_debouncer;
  localparam int N   = 4;
  localparam int STB = 4;
  localparam int LNG = 10;
  localparam int CW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_debouncer_if #(.N_CH(N)) bus ();

  multi_debouncer #(
    .N_CH(N), .CNT_W(CW), .STABLE_CYCLES(STB), .LONG_CYCLES(LNG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         e_edge;
    logic [N-1:0] dout;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] lp;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: history of inputs seen at each active edge since
  // reset release (edge 1 is the first edge after release).
  logic [N-1:0] d_hist[$];
  logic         en_hist[$];
  logic [N-1:0] m_dout;
  int           m_last_chg[N];
  int           m_hold[N];

  // Event statistics gathered by the monitor for the directed timing checks.
  int rise_edge[N], fall_edge[N], lp_edge[N];
  int rise_cnt[N], fall_cnt[N], lp_cnt[N];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic model_clear();
    d_hist.delete();
    en_hist.delete();
    m_dout = '0;
    for (int c = 0; c < N; c++) begin
      m_last_chg[c] = 0;
      m_hold[c] = 0;
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < N; c++) begin
      rise_edge[c] = -1; fall_edge[c] = -1; lp_edge[c] = -1;
      rise_cnt[c] = 0;   fall_cnt[c] = 0;   lp_cnt[c] = 0;
    end
  endtask

  // The synchronised level seen at edge m is din as sampled two edges earlier.
  // Output flips once STB qualified mismatching samples have accumulated since
  // the last output change or the last matching sample.
  task automatic model_step(input logic [N-1:0] d, input logic en, output exp_t e);
    int j;
    logic [N-1:0] nd;
    logic [N-1:0] lp;
    d_hist.push_back(d);
    en_hist.push_back(en);
    j = d_hist.size();
    nd = m_dout;
    lp = '0;
    for (int c = 0; c < N; c++) begin
      int cnt;
      logic sm;
      cnt = 0;
      for (int m = j; m > m_last_chg[c]; m--) begin
        sm = (m >= 3) ? d_hist[m-3][c] : 1'b0;
        if (sm == m_dout[c]) break;
        if (en_hist[m-1]) cnt++;
      end
      if (cnt == STB) begin
        nd[c] = ~m_dout[c];
        m_last_chg[c] = j;
      end
      if (m_dout[c]) begin
        if (en && m_hold[c] < LNG) begin
          m_hold[c]++;
`ifdef DEB_LONG_PRESS_EN
          lp[c] = (m_hold[c] == LNG);
`endif
        end
      end else begin
        m_hold[c] = 0;
      end
    end
    e.e_edge = edge_cnt + 1;
    e.dout = nd;
    e.rise = nd & ~m_dout;
    e.fall = ~nd & m_dout;
    e.lp   = lp;
    m_dout = nd;
  endtask

  // Drive one cycle of stimulus (just after a falling edge) and queue the
  // expected outputs for the next rising edge.
  task automatic drive(input logic [N-1:0] d, input logic en);
    exp_t e;
    bus.i_din = d;
    bus.i_sample_en = en;
    model_step(d, en, e);
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check("reset_outputs_zero", int'({bus.o_dout, bus.o_rise, bus.o_fall, bus.o_long_press}), 0);
    exp_q.delete();
    model_clear();
    repeat (cycles) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT against the queued expectation for this edge.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].e_edge < edge_cnt) begin
        exp_t s;
        s = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL scoreboard_stale: expectation for edge %0d unchecked at edge %0d", s.e_edge, edge_cnt);
      end
      if (exp_q.size() > 0 && exp_q[0].e_edge == edge_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.o_dout !== e.dout || bus.o_rise !== e.rise ||
            bus.o_fall !== e.fall || bus.o_long_press !== e.lp) begin
          errors++;
          $display("FAIL scoreboard edge %0d: got dout=%b rise=%b fall=%b lp=%b, required dout=%b rise=%b fall=%b lp=%b",
                   edge_cnt, bus.o_dout, bus.o_rise, bus.o_fall, bus.o_long_press,
                   e.dout, e.rise, e.fall, e.lp);
        end
        checks++;
        if ((bus.o_rise & bus.o_fall) != '0) begin
          errors++;
          $display("FAIL rise_and_fall_together edge %0d: got %b, required 0", edge_cnt, bus.o_rise & bus.o_fall);
        end
      end
      for (int c = 0; c < N; c++) begin
        if (bus.o_rise[c]) begin rise_edge[c] = edge_cnt; rise_cnt[c]++; end
        if (bus.o_fall[c]) begin fall_edge[c] = edge_cnt; fall_cnt[c]++; end
        if (bus.o_long_press[c]) begin lp_edge[c] = edge_cnt; lp_cnt[c]++; end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, tr;
    logic [N-1:0] d;
    bus.i_din = '0;
    bus.i_sample_en = 1'b1;
    model_clear();
    clear_stats();
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", int'({bus.o_dout, bus.o_rise, bus.o_fall, bus.o_long_press}), 0);
    rst_n = 1'b1;

    repeat (8) drive('0, 1'b1);

    // Clean step on channel 0.
    clear_stats();
    t0 = edge_cnt;
    repeat (12) drive(4'b0001, 1'b1);
    check("step_rise_latency", rise_edge[0] - t0, 2 + STB);
    check("step_rise_count", rise_cnt[0], 1);

    // Bouncing channel 1: 1,0,1 then hold.
    clear_stats();
    drive(4'b0011, 1'b1);
    drive(4'b0001, 1'b1);
    t0 = edge_cnt;
    repeat (12) drive(4'b0011, 1'b1);
    check("bounce_rise_latency", rise_edge[1] - t0, 2 + STB);
    check("bounce_rise_count", rise_cnt[1], 1);

    // Channel 2 with sample_en on every second cycle.
    clear_stats();
    t0 = edge_cnt;
    for (int k = 0; k < 16; k++) drive(4'b0111, k[0]);
    check("prescaled_rise_latency", rise_edge[2] - t0, 2 + 2 * STB);

    // All channels together.
    repeat (10) drive('0, 1'b1);
    clear_stats();
    t0 = edge_cnt;
    repeat (10) drive(4'b1111, 1'b1);
    for (int c = 0; c < N; c++) check($sformatf("all_rise_ch%0d", c), rise_edge[c] - t0, 2 + STB);
    t1 = edge_cnt;
    repeat (10) drive('0, 1'b1);
    for (int c = 0; c < N; c++) check($sformatf("all_fall_ch%0d", c), fall_edge[c] - t1, 2 + STB);

    // Reset in the middle of qualification on channel 3 (counter at 3).
    repeat (10) drive('0, 1'b1);
    repeat (5) drive(4'b1000, 1'b1);
    do_reset(3);
    clear_stats();
    tr = edge_cnt;
    repeat (10) drive(4'b1000, 1'b1);
    check("post_reset_rise_latency", rise_edge[3] - tr, 2 + STB);
    check("post_reset_rise_count", rise_cnt[3], 1);

    // Long hold on channel 0.
    clear_stats();
    t0 = edge_cnt;
    repeat (25) drive(4'b1001, 1'b1);
    check("hold_rise_latency", rise_edge[0] - t0, 2 + STB);
`ifdef DEB_LONG_PRESS_EN
    check("long_press_delay", lp_edge[0] - rise_edge[0], LNG);
    check("long_press_count", lp_cnt[0], 1);
`else
    check("long_press_absent", lp_cnt[0], 0);
`endif

    // Randomized traffic with a random sample qualifier.
    d = '0;
    for (int k = 0; k < 1200; k++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(5) == 0) d[c] = ~d[c];
      drive(d, $urandom_range(3) != 0);
    end
    do_reset(1 + $urandom_range(3));
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(9) == 0) d[c] = ~d[c];
      drive(d, 1'b1);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter N_CH, default 8, number of independent input channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of each per-channel stability counter.
REQ-003 Parameter STABLE_CYCLES, default 1000, qualified samples a changed level must persist before output follows (1..2^CNT_W-1).
REQ-004 Parameter LONG_CYCLES, default 50000, qualified samples of held-high output before long-press pulse (1..2^CNT_W-1; used only with DEB_LONG_PRESS_EN).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 din  input  N_CH  raw asynchronous inputs (switches/buttons).
REQ-008 sample_en  input  1  sample qualifier/prescaler tick; tie high for per-cycle sampling.
REQ-009 dout  output  N_CH  debounced level per channel, registered.
REQ-010 rise  output  N_CH  one-cycle pulse on dout 0->1, registered.
REQ-011 fall  output  N_CH  one-cycle pulse on dout 1->0, registered.
REQ-012 long_press  output  N_CH  one-cycle long-hold pulse; constant 0 without DEB_LONG_PRESS_EN.

Function
REQ-013 Each din bit SHALL pass a 2-flop synchroniser; s[i] denotes the second flop.
REQ-014 Cycle with s[i]==dout[i]: counter[i] SHALL clear to 0.
REQ-015 Cycle with s[i]!=dout[i] and sample_en=1: counter[i] SHALL increment; sample_en=0: counter[i] SHALL hold.
REQ-016 On the edge sampling the STABLE_CYCLES-th consecutive qualified mismatch, dout[i] SHALL take s[i] and counter[i] SHALL clear.
REQ-017 With sample_en held 1, dout SHALL change exactly 2+STABLE_CYCLES cycles after a clean din step.
REQ-018 Any single cycle of s[i]==dout[i] during counting (bounce) SHALL restart qualification from 0.
REQ-019 rise[i]/fall[i] SHALL be high only in the first cycle dout[i] shows the new level; never both high.
REQ-020 Counters SHALL never wrap; constraints REQ-003/004 guarantee range.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels all resolve in the same cycle.

Reset
REQ-022 rst_n low SHALL immediately clear synchronisers, counters, dout, rise, fall, long_press to 0.
REQ-023 Reset mid-qualification SHALL discard progress; after release a held-high din rises dout after 2+STABLE_CYCLES cycles.
REQ-024 Outputs SHALL show no pulse in the first cycle after reset release.

Configuration
REQ-025 Macro DEB_LONG_PRESS_EN defined: per-channel hold counter increments on sample_en while dout[i]=1, clears when dout[i]=0.
REQ-026 Hold counter reaching LONG_CYCLES: long_press[i] SHALL pulse one cycle, counter saturates; no re-fire until dout[i] falls.
REQ-027 Macro undefined: no hold counters instantiated; long_press tied 0; all other behaviour identical.

Verification (STABLE_CYCLES=4, LONG_CYCLES=10, N_CH=4, sample_en=1 unless stated)
REQ-028 din[0] 0->1 clean step -> dout[0]=1 and rise[0]=1 exactly 6 cycles later, rise for 1 cycle only.
REQ-029 din[1] toggles 1,0,1 each cycle then holds 1 -> dout[1] rises 6 cycles after final edge; no earlier rise.
REQ-030 sample_en high every 2nd cycle, din[2] step -> dout[2] changes after 4 qualified samples (~2+8 cycles).
REQ-031 din=4'b1111 at once -> all dout bits and rise bits assert same cycle; later din=0 -> fall=4'b1111 together.
REQ-032 din[3] high, rst_n pulsed low at count 3 -> dout, counters 0 at once; dout[3] rises 6 cycles after release.
REQ-033 Macro defined, din[0] held high -> long_press[0] pulses once 10 cycles after dout[0] rise; undefined -> never.
